// File: rtl/hi_lo_unit_pkg.sv
// Shared types for the HI/LO unit: op classes, FSM encoding, default width.
// HI_LO_DIV_EN adds the DIV state used by the optional iterative divider.
package hi_lo_unit_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MULT = 3'd1,
        OP_MADD = 3'd2,
        OP_MSUB = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5,
        OP_DIV  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef HI_LO_DIV_EN
        , ST_DIV = 2'd2
`endif
    } state_e;

    // Decoder flags to op class, highest priority first.
    function automatic op_e decode_op(input logic hw, input logic lw, input logic madd,
                                      input logic msub, input logic div);
        if (madd && msub) return OP_NONE;
        if (madd)         return OP_MADD;
        if (msub)         return OP_MSUB;
        if (div)          return OP_DIV;
        if (hw && lw)     return OP_MULT;
        if (hw)           return OP_MTHI;
        if (lw)           return OP_MTLO;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/hi_lo_divider.sv
// Restoring divider, one quotient bit per step; signs fixed on the magnitudes at the end.
// Latency: load + DATA_W steps; no backpressure, the parent sequences load/step.
module hi_lo_divider
    import hi_lo_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              sgn,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem, quo, dvs, raw_dvd;
    logic              neg_q, neg_r, dvz;
    logic              neg_a, neg_b;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] sub;
    logic              fits;

    assign neg_a   = sgn & dividend[DATA_W-1];
    assign neg_b   = sgn & divisor[DATA_W-1];
    assign shifted = {rem, quo[DATA_W-1]};
    assign fits    = shifted >= {1'b0, dvs};
    // The true difference is below dvs, so the low DATA_W bits are exact.
    assign sub     = shifted[DATA_W-1:0] - dvs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            raw_dvd <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dvz     <= 1'b0;
        end else if (load) begin
            rem     <= '0;
            quo     <= neg_a ? -dividend : dividend;
            dvs     <= neg_b ? -divisor : divisor;
            raw_dvd <= dividend;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            dvz     <= (divisor == '0);
        end else if (step) begin
            rem <= fits ? sub : shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], fits};
        end
    end

    assign quotient  = dvz ? '1 : (neg_q ? -quo : quo);
    assign remainder = dvz ? raw_dvd : (neg_r ? -rem : rem);

endmodule

// File: rtl/hi_lo_unit.sv
// HI/LO register owner: mthi/mtlo in one edge, mult/madd/msub after MUL_LATENCY busy cycles.
// Busy high while an op runs; flags seen during Busy are dropped. HI_LO_DIV_EN adds div.
module hi_lo_unit
    import hi_lo_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              HiWrite,
    input  logic              LoWrite,
    input  logic              Madd,
    input  logic              Msub,
    input  logic              Signed,
    input  logic              HiOrLo,
`ifdef HI_LO_DIV_EN
    input  logic              Div,
`endif
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    output logic [DATA_W-1:0] HiLoOut,
    output logic              Busy,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int CNT_W = $clog2(DATA_W + MUL_LATENCY + 1);

    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
    op_e                 op_q, op_dec;
    logic [DATA_W-1:0]   op_a, op_b;
    logic                op_sgn;
    logic                accept;
    logic                div_flag;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod, pair, acc;

`ifdef HI_LO_DIV_EN
    logic              div_load, div_step;
    logic [DATA_W-1:0] div_quo, div_rem;

    assign div_flag = Div;

    hi_lo_divider #(.DATA_W(DATA_W)) u_div (
        .clk       (Clk),
        .rst       (Reset),
        .load      (div_load),
        .step      (div_step),
        .sgn       (Signed),
        .dividend  (RsData),
        .divisor   (RtData),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign div_flag = 1'b0;
`endif

    assign op_dec = decode_op(HiWrite, LoWrite, Madd, Msub, div_flag);

    assign ext_a = {{DATA_W{op_sgn & op_a[DATA_W-1]}}, op_a};
    assign ext_b = {{DATA_W{op_sgn & op_b[DATA_W-1]}}, op_b};
    assign prod  = ext_a * ext_b;
    assign pair  = {hi_q, lo_q};

    always_comb begin
        case (op_q)
            OP_MADD: acc = pair + prod;
            OP_MSUB: acc = pair - prod;
            default: acc = prod;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hi_d    = hi_q;
        lo_d    = lo_q;
        accept  = 1'b0;
`ifdef HI_LO_DIV_EN
        div_load = 1'b0;
        div_step = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                case (op_dec)
                    OP_MTHI: hi_d = RsData;
                    OP_MTLO: lo_d = RsData;
                    OP_MULT, OP_MADD, OP_MSUB: begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end
`ifdef HI_LO_DIV_EN
                    OP_DIV: begin
                        accept   = 1'b1;
                        div_load = 1'b1;
                        state_d  = ST_DIV;
                        cnt_d    = CNT_W'(DATA_W);
                    end
`endif
                    default: ;
                endcase
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    {hi_d, lo_d} = acc;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
`ifdef HI_LO_DIV_EN
            ST_DIV: begin
                if (cnt == '0) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= OP_NONE;
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (accept) begin
                op_q   <= op_dec;
                op_a   <= RsData;
                op_b   <= RtData;
                op_sgn <= Signed;
            end
        end
    end

    assign Busy    = (state != ST_IDLE);
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign HiLoOut = HiOrLo ? hi_q : lo_q;

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
Owns the architectural HI/LO registers and executes the multi-cycle ops the instruction decoder flags: mult/multu, madd/msub, mthi/mtlo, and the read path for mfhi/mflo. It sits beside the ALU in EX. It raises Busy so the hazard logic stalls issue while an op is in flight.

Parameters:
MUL_LATENCY, 3, cycles from op acceptance to the HI/LO update for mult/madd/msub (legal range 1..8).
DATA_W, 32, register/operand width. HI/LO pair is 2*DATA_W.

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
HiWrite  in  1  decoder flag: write HI (mthi, or mult when paired with LoWrite)
LoWrite  in  1  decoder flag: write LO (mtlo, or mult when paired with HiWrite)
Madd  in  1  decoder flag: {HI,LO} += Rs*Rt
Msub  in  1  decoder flag: {HI,LO} -= Rs*Rt
Signed  in  1  1 = signed multiply (mult/madd/msub), 0 = unsigned (multu)
HiOrLo  in  1  read select: 1 = HI, 0 = LO
RsData  in  DATA_W  operand A / mthi-mtlo source
RtData  in  DATA_W  operand B
HiLoOut  out  DATA_W  HiOrLo ? HI : LO, combinational from the registers
Busy  out  1  op in flight; new ops are ignored
Hi  out  DATA_W  HI register (debug/forwarding)
Lo  out  DATA_W  LO register

Behaviour:
- Reset (async, any state): HI=0, LO=0, Busy=0, FSM=IDLE, counter=0, operand and product latches=0. A reset in mid-op aborts the op with no HI/LO update.
- Op decode is sampled only in IDLE, with priority:
  - Madd&Msub both high: no-op.
  - Madd: MADD.
  - Msub: MSUB.
  - HiWrite&LoWrite: MULT.
  - HiWrite only: MTHI.
  - LoWrite only: MTLO.
  - Otherwise: none.
- MTHI/MTLO: at the next edge, HI (or LO) takes RsData. Busy stays 0. Zero extra latency.
- MULT/MADD/MSUB:
  - At the accepting edge, latch RsData, RtData and Signed. Go IDLE->RUN, counter=MUL_LATENCY-1, Busy=1.
  - Product P = 64-bit product of the two operands: both sign-extended if Signed, else zero-extended.
  - RUN decrements the counter each cycle. At the edge where the counter reaches 0, write the result and return to IDLE; Busy falls in that same edge.
  - MULT: {HI,LO}=P. MADD: {HI,LO}={HI,LO}+P mod 2^64. MSUB: {HI,LO}={HI,LO}-P mod 2^64. Overflow wraps silently.
  - MUL_LATENCY=1: Busy is high for exactly one cycle.
- While Busy=1, every decoder flag is ignored, including mthi/mtlo. The hazard unit must stall on Busy; ops issued during Busy are not queued.
- HiLoOut during Busy shows the pre-op value. mfhi/mflo correctness is guaranteed by the stall, not by this unit.
- An op issued in the cycle Busy falls: that cycle is IDLE, so the op is accepted and back-to-back madds chain correctly.
- FSM states: IDLE, RUN (plus DIV when the optional feature is compiled in). Illegal state encodings recover to IDLE.

Optional Feature:
HI_LO_DIV_EN
- Compiled in:
  - Adds input Div (1) and state DIV. Div is decoded with priority below Msub and above MULT.
  - Runs a 32-iteration restoring divide, one bit per cycle, so Busy is high for 33 cycles. Signed mode divides magnitudes and fixes signs at the end.
  - Result: LO=quotient, HI=remainder. Remainder takes the dividend's sign, quotient truncates toward zero.
  - Divide by zero: LO=all ones, HI=RsData.
- Compiled out: no Div port and no DIV state. Area equals the base block.

Decomposition:
- Shared package holds:
  - op-class enum: OP_NONE, OP_MULT, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_DIV;
  - FSM state encoding;
  - DATA_W default.
- One sub-module, hi_lo_divider, holds the iterative divide datapath. It is instantiated only under HI_LO_DIV_EN.
- Multiply and accumulate stay inline.

Test Plan:
- Reset mid-RUN (mult issued, Reset asserted in cycle 2) -> HI=LO=0, Busy=0 immediately; no late write after release.
- mult Signed=1, Rs=0xFFFFFFFF, Rt=2 -> after 3 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE. Busy high for exactly 3 cycles.
- mthi Rs=0x12345678, then mflo/mfhi reads -> HiLoOut=0x12345678 with HiOrLo=1 the next cycle. mthi asserted during Busy -> HI unchanged.
- HI=0, LO=0xFFFFFFFF, madd Rs=1 Rt=1 -> HI=1, LO=0 (carry across the pair). msub Rs=1 Rt=1 issued on the Busy-fall cycle -> HI=0, LO=0xFFFFFFFF. Madd&Msub both high -> no change, Busy stays 0.
- MUL_LATENCY=1 build: back-to-back madd of 3*4 and 5*6 from zero -> LO=42, Busy high one cycle per op.
- HI_LO_DIV_EN build: div Rs=-7 Rt=2 signed -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 busy cycles. Rt=0, Rs=9 -> LO=0xFFFFFFFF, HI=9.
